// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that funnels N_REQ requesters into one FIFO write port.
// Optional macro FIFO_WR_ARBITER_SRC_TAG_EN prepends the source index to fifo_wr_data.
module fifo_wr_arbiter #(
  parameter int WIDTH_DATA = 8,
  parameter int N_REQ      = 4,
  parameter int NUMWORDS   = 16,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int USED_W    = $clog2(NUMWORDS + 1),
`ifdef FIFO_WR_ARBITER_SRC_TAG_EN
  localparam int FIFO_W    = WIDTH_DATA + IDX_W
`else
  localparam int FIFO_W    = WIDTH_DATA
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*WIDTH_DATA-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [USED_W-1:0]           fifo_usedw,
  output logic                        fifo_wr_en,
  output logic [FIFO_W-1:0]           fifo_wr_data,
  output logic [IDX_W-1:0]            src_idx,
  output logic                        busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic [7:0]            beat_cnt;
  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      search_base;
  logic [WIDTH_DATA-1:0] pick_data;
  logic                  room;
  logic                  owner_hold;
  logic                  found;
  logic                  xfer;
  logic                  start_grant;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    next_idx = (i == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : i + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

  // The write being presented this cycle counts against the fill level; one extra bit avoids wrap.
  assign room = ({1'b0, fifo_usedw} + {{USED_W{1'b0}}, fifo_wr_en}) < (USED_W + 1)'(NUMWORDS);

  // Grant selection: a valid locked owner wins, otherwise search upward from the rotation base.
  always_comb begin
    int s;
    owner_hold  = (state == ST_BURST) && req_valid[owner];
    search_base = (state == ST_BURST) ? next_idx(owner) : ptr;
    found       = 1'b0;
    pick        = {IDX_W{1'b0}};
    s           = 0;
    if (owner_hold) begin
      found = 1'b1;
      pick  = owner;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        s = int'(search_base) + k;
        if (s >= N_REQ) begin
          s = s - N_REQ;
        end else begin
          s = s;
        end
        if (req_valid[s]) begin
          found = 1'b1;
          pick  = IDX_W'(s);
        end else begin
          found = found;
        end
      end
    end
    xfer        = found && room && !rst;
    start_grant = xfer && !owner_hold;
    pick_data   = req_data[pick*WIDTH_DATA +: WIDTH_DATA];
  end

  // One-hot ready decode of the selected requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = xfer && (pick == IDX_W'(i));
    end
  end

  assign busy = (state == ST_BURST);

  // Burst FSM, rotation pointer and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= {IDX_W{1'b0}};
      owner        <= {IDX_W{1'b0}};
      beat_cnt     <= 8'd0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= {FIFO_W{1'b0}};
      src_idx      <= {IDX_W{1'b0}};
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        src_idx <= pick;
`ifdef FIFO_WR_ARBITER_SRC_TAG_EN
        fifo_wr_data <= {pick, pick_data};
`else
        fifo_wr_data <= pick_data;
`endif
      end

      if (start_grant) begin
        owner    <= pick;
        beat_cnt <= 8'd1;
        if (MAX_BURST > 1) begin
          state <= ST_BURST;
          // A new grant that replaces a dropped owner still rotates past that owner.
          if (state == ST_BURST) begin
            ptr <= next_idx(owner);
          end
        end else begin
          state <= ST_IDLE;
          ptr   <= next_idx(pick);
        end
      end else if (owner_hold) begin
        if (xfer) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (beat_cnt == 8'(MAX_BURST - 1)) begin
            state <= ST_IDLE;
            ptr   <= next_idx(owner);
          end
        end
      end else if (state == ST_BURST) begin
        state <= ST_IDLE;
        ptr   <= next_idx(owner);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter with an in-bench grant/FIFO reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, DEPTH = 16, MB = 4;
`ifdef FIFO_WR_ARBITER_SRC_TAG_EN
  localparam int FW = W + 2;
`else
  localparam int FW = W;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [4:0]    fifo_usedw;
  logic          fifo_wr_en;
  logic [FW-1:0] fifo_wr_data;
  logic [1:0]    src_idx;
  logic          busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH_DATA(W), .N_REQ(N), .NUMWORDS(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_usedw(fifo_usedw), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .src_idx(src_idx), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  int occ = 0;
  bit rd = 1'b0;

  // Reference model: who owns the grant, how many beats taken, where rotation resumes.
  bit          m_burst = 1'b0;
  int          m_owner = 0, m_beats = 0, m_ptr = 0, m_src = 0;
  bit          m_wr_en = 1'b0;
  logic [FW-1:0] m_data = '0;
  logic [N-1:0]  exp_ready, last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int s;
    if (rst) return -1;
    if (m_burst && req_valid[m_owner]) return m_owner;
    s = m_burst ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  // One clock: check outputs/ready against the model, clock, advance model and FIFO level.
  task automatic step();
    int g;
    bit room;
    fifo_usedw = 5'(occ);
    #1;
    room = (occ + int'(m_wr_en)) < DEPTH;
    g = model_grant();
    exp_ready = (g >= 0 && room) ? N'(1 << g) : '0;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
    chk("fifo_wr_data", 32'(fifo_wr_data), 32'(m_data));
    chk("src_idx", 32'(src_idx), 32'(m_src));
    chk("busy", 32'(busy), 32'(m_burst));
    chk("no_write_when_full", 32'(fifo_wr_en && occ >= DEPTH), 32'(0));
    @(posedge clk);
    occ = occ + int'(m_wr_en) - ((rd && occ > 0) ? 1 : 0);
    if (rst) begin
      m_burst = 1'b0; m_owner = 0; m_beats = 0; m_ptr = 0;
      m_wr_en = 1'b0; m_data = '0; m_src = 0;
    end else begin
      if (m_burst && !req_valid[m_owner]) begin
        m_burst = 1'b0;
        m_ptr = (m_owner + 1) % N;
      end
      if (exp_ready != '0) begin
        if (m_burst) begin
          m_beats++;
          if (m_beats == MB) begin
            m_burst = 1'b0;
            m_ptr = (m_owner + 1) % N;
          end
        end else begin
          m_owner = g;
          m_beats = 1;
          if (MB > 1) m_burst = 1'b1;
          else m_ptr = (g + 1) % N;
        end
        m_wr_en = 1'b1;
`ifdef FIFO_WR_ARBITER_SRC_TAG_EN
        m_data = {2'(g), req_data[g*W +: W]};
`else
        m_data = req_data[g*W +: W];
`endif
        m_src = g;
      end else begin
        m_wr_en = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '1;
    rd = 1'b0;
    step();
    chk("rst_ready", 32'(last_ready), 32'(0));
    chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("rst_wr_data", 32'(fifo_wr_data), 32'(0));
    chk("rst_src_idx", 32'(src_idx), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    req_valid = '0;
    occ = 0;
  endtask

  initial begin
    int nw;
    int rd_pct;
    logic [FW-1:0] exp36;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_usedw = '0;
    @(posedge clk);
    @(negedge clk);
    reset_dut();

    // Single requester, FIFO never drained: exactly DEPTH writes then stall.
    req_valid = 4'b0100; rd = 1'b0; nw = 0;
    for (int i = 0; i < 24; i++) begin
      req_data = $urandom;
      step();
      if (fifo_wr_en) nw++;
    end
    chk("fill_write_count", 32'(nw), 32'(16));
    chk("fill_stalled_ready", 32'(last_ready), 32'(0));

    // All requesters valid, FIFO drained every cycle: bursts of 4 in rotation, no bubbles.
    reset_dut();
    req_valid = 4'b1111; rd = 1'b1;
    for (int k = 0; k < 18; k++) begin
      req_data = $urandom;
      step();
      chk("rr_src_seq", 32'(src_idx), 32'((k / 4) % 4));
      chk("rr_no_idle", 32'(fifo_wr_en), 32'(1));
    end

    // Owner 1 drops after 2 beats, requester 3 picked up in the same cycle.
    reset_dut();
    req_valid = 4'b0010; rd = 1'b1;
    step(); chk("drop_src0", 32'(src_idx), 32'(1));
    step(); chk("drop_src1", 32'(src_idx), 32'(1));
    req_valid = 4'b1000;
    step();
    chk("drop_ready_same_cycle", 32'(last_ready), 32'(4'b1000));
    chk("drop_src2", 32'(src_idx), 32'(3));

    // Reset mid-burst discards it; rotation restarts at requester 0 with a full burst.
    reset_dut();
    req_valid = 4'b1111; rd = 1'b1;
    step(); step();
    chk("midrst_beat2", 32'(src_idx), 32'(0));
    rst = 1'b1;
    step();
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'(0));
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("midrst_src", 32'(src_idx), 32'((k < 4) ? 0 : 1));
    end

    // usedw=15 with a write in flight leaves no room.
    reset_dut();
    req_valid = 4'b1111; rd = 1'b0;
    step();
    occ = 15;
    step();
    chk("almost_full_ready", 32'(last_ready), 32'(0));

    // Payload (and optional tag) on the FIFO port one cycle after the transfer.
    reset_dut();
    req_valid = 4'b1000; req_data = 32'hA500_0000; rd = 1'b1;
    step();
`ifdef FIFO_WR_ARBITER_SRC_TAG_EN
    exp36 = 10'b11_1010_0101;
`else
    exp36 = 8'hA5;
`endif
    chk("payload_a5", 32'(fifo_wr_data), 32'(exp36));
    chk("payload_src", 32'(src_idx), 32'(3));

    // Randomized traffic with sticky valids, varying drain rate and rare resets.
    reset_dut();
    rd_pct = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) rd_pct = $urandom_range(0, 3) * 33 + 1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req_valid[b] = ~req_valid[b];
      end
      req_data = $urandom;
      rd = ($urandom_range(0, 99) < rd_pct);
      rst = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
